// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: captures an issued branch, evaluates it on the shared comparator,
// then redirects fetch on a mispredict and reports the result. Optional counters under BRU_PERF_EN.
module branch_resolve_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_sel,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_pred_taken,
  output logic [2:0]        cmp_sel,
  output logic [DATA_W-1:0] cmp_drs1,
  output logic [DATA_W-1:0] cmp_drs2,
  input  logic              cmp_take,
  input  logic              kill,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic              res_mispred
`ifdef BRU_PERF_EN
  ,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispreds
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIR, RESP} state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_sel;
  logic [DATA_W-1:0] r_rs1, r_rs2, r_pc, r_imm, r_target;
  logic              r_pred, r_taken, r_mispred;
  logic              w_accept, w_br_sel, w_taken, w_mispred;
  logic [DATA_W-1:0] w_target;

  assign w_accept  = (r_state == IDLE) && in_valid && !kill;
  // Ops 0 (nop) and 7 (reserved) never take, whatever the comparator says.
  assign w_br_sel  = (r_sel != 3'd0) && (r_sel != 3'd7);
  assign w_taken   = w_br_sel && cmp_take;
  assign w_mispred = w_taken != r_pred;
  assign w_target  = w_taken ? (r_pc + r_imm) : (r_pc + DATA_W'(4));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = EVAL;
      EVAL:    if (kill) w_next = IDLE;
               else      w_next = w_mispred ? REDIR : RESP;
      REDIR:   if (kill) w_next = IDLE;
               else if (redirect_ready) w_next = RESP;
      RESP:    if (kill || res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Capture stage: operands held for the whole lifetime of the branch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel  <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_pc   <= '0;
      r_imm  <= '0;
      r_pred <= 1'b0;
    end else if (w_accept) begin
      r_sel  <= in_sel;
      r_rs1  <= in_rs1;
      r_rs2  <= in_rs2;
      r_pc   <= in_pc;
      r_imm  <= in_imm;
      r_pred <= in_pred_taken;
    end
  end

  // Evaluate stage: outcome and target frozen for the redirect/response handshakes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_taken   <= 1'b0;
      r_mispred <= 1'b0;
      r_target  <= '0;
    end else if (r_state == EVAL) begin
      r_taken   <= w_taken;
      r_mispred <= w_mispred;
      r_target  <= w_target;
    end
  end

`ifdef BRU_PERF_EN
  logic [31:0] r_perf_branches, r_perf_mispreds;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_branches <= '0;
      r_perf_mispreds <= '0;
    end else begin
      if ((r_state == RESP) && res_ready && !kill && w_br_sel)
        r_perf_branches <= r_perf_branches + 32'd1;
      if ((r_state == REDIR) && redirect_ready && !kill)
        r_perf_mispreds <= r_perf_mispreds + 32'd1;
    end
  end

  assign perf_branches = r_perf_branches;
  assign perf_mispreds = r_perf_mispreds;
`endif

  assign in_ready       = (r_state == IDLE);
  assign cmp_sel        = (r_state == EVAL) ? r_sel : 3'd0;
  assign cmp_drs1       = r_rs1;
  assign cmp_drs2       = r_rs2;
  assign redirect_valid = (r_state == REDIR);
  assign redirect_pc    = r_target;
  assign res_valid      = (r_state == RESP);
  assign res_taken      = r_taken;
  assign res_mispred    = r_mispred;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; perf-counter scenarios build only with BRU_PERF_EN.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  in_sel = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
  logic        in_pred_taken = 1'b0;
  logic [2:0]  cmp_sel;
  logic [31:0] cmp_drs1, cmp_drs2;
  logic        cmp_take;
  logic        kill = 1'b0;
  logic        redirect_valid, redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic        res_valid, res_ready = 1'b0, res_taken, res_mispred;
`ifdef BRU_PERF_EN
  logic [31:0] perf_branches, perf_mispreds;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Shared comparator as seen by the block
  always_comb begin
    cmp_take = 1'b0;
    case (cmp_sel)
      3'd1: cmp_take = (cmp_drs1 == cmp_drs2);
      3'd2: cmp_take = (cmp_drs1 != cmp_drs2);
      3'd3: cmp_take = ($signed(cmp_drs1) <  $signed(cmp_drs2));
      3'd4: cmp_take = ($signed(cmp_drs1) >= $signed(cmp_drs2));
      3'd5: cmp_take = (cmp_drs1 <  cmp_drs2);
      3'd6: cmp_take = (cmp_drs1 >= cmp_drs2);
      default: cmp_take = 1'b0;
    endcase
  end

  branch_resolve_ctrl dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken),
    .cmp_sel(cmp_sel), .cmp_drs1(cmp_drs1), .cmp_drs2(cmp_drs2), .cmp_take(cmp_take),
    .kill(kill),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken), .res_mispred(res_mispred)
`ifdef BRU_PERF_EN
    , .perf_branches(perf_branches), .perf_mispreds(perf_mispreds)
`endif
  );

  always @(posedge clk) begin
    if (rstn && redirect_valid && res_valid) begin
      errors++;
      $display("FAIL both_valid: redirect_valid=1 res_valid=1 at %0t, required at most one", $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one branch for a single accepted edge; returns #1 after that edge (cycle N+1).
  task automatic issue(input logic [2:0] sel, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    in_sel = sel; in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm; in_pred_taken = pred;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (redirect_valid !== 1'b0 || res_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valids: got redir=%b res=%b want 0 0", redirect_valid, res_valid); end
    checks++; if (res_taken !== 1'b0 || res_mispred !== 1'b0) begin errors++;
      $display("FAIL rst_res: got taken=%b mispred=%b want 0 0", res_taken, res_mispred); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc: got %h want 0", redirect_pc); end
    checks++; if (cmp_sel !== 3'd0 || cmp_drs1 !== 32'h0 || cmp_drs2 !== 32'h0) begin errors++;
      $display("FAIL rst_cmp: got sel=%0d drs1=%h drs2=%h want 0 0 0", cmp_sel, cmp_drs1, cmp_drs2); end
`ifdef BRU_PERF_EN
    checks++; if (perf_branches !== 32'h0 || perf_mispreds !== 32'h0) begin errors++;
      $display("FAIL rst_perf: got %h %h want 0 0", perf_branches, perf_mispreds); end
`endif
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_beq_predicted();
    issue(3'd1, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
    checks++; if (in_ready !== 1'b0 || cmp_sel !== 3'd1 || cmp_drs1 !== 32'd5) begin errors++;
      $display("FAIL beq_eval: got ready=%b sel=%0d drs1=%h want 0 1 5", in_ready, cmp_sel, cmp_drs1); end
    checks++; if (res_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++;
      $display("FAIL beq_early: got res=%b redir=%b want 0 0", res_valid, redirect_valid); end
    step();
    checks++; if (res_valid !== 1'b1 || redirect_valid !== 1'b0 || res_taken !== 1'b1 || res_mispred !== 1'b0) begin errors++;
      $display("FAIL beq_res: got v=%b rv=%b t=%b m=%b want 1 0 1 0", res_valid, redirect_valid, res_taken, res_mispred); end
    checks++; if (cmp_sel !== 3'd0) begin errors++; $display("FAIL beq_cmp_sel_idle: got %0d want 0", cmp_sel); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL beq_done: got res=%b ready=%b want 0 1", res_valid, in_ready); end
  endtask

  task automatic test_blt_redirect();
    issue(3'd3, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0);
    step();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h240 || res_valid !== 1'b0) begin errors++;
      $display("FAIL blt_redir: got v=%b pc=%h res=%b want 1 00000240 0", redirect_valid, redirect_pc, res_valid); end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checks++; if (res_valid !== 1'b1 || redirect_valid !== 1'b0 || res_taken !== 1'b1 || res_mispred !== 1'b1) begin errors++;
      $display("FAIL blt_res: got v=%b rv=%b t=%b m=%b want 1 0 1 1", res_valid, redirect_valid, res_taken, res_mispred); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL blt_done: got ready=%b want 1", in_ready); end
  endtask

  task automatic test_bltu_stall();
    issue(3'd5, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204) begin errors++;
        $display("FAIL bltu_hold%0d: got v=%b pc=%h want 1 00000204", i, redirect_valid, redirect_pc); end
      step();
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_mispred !== 1'b1) begin errors++;
      $display("FAIL bltu_res: got v=%b t=%b m=%b want 1 0 1", res_valid, res_taken, res_mispred); end
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bltu_res_hold: got %b want 1", res_valid); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_kill_redir();
    logic [31:0] mis_before;
    mis_before = 32'h0;
`ifdef BRU_PERF_EN
    mis_before = perf_mispreds;
`endif
    issue(3'd3, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 1'b0);
    step();
    kill = 1'b1; redirect_ready = 1'b1;
    step();
    kill = 1'b0; redirect_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || redirect_valid !== 1'b0 || res_valid !== 1'b0) begin errors++;
      $display("FAIL kill_redir: got ready=%b rv=%b res=%b want 1 0 0", in_ready, redirect_valid, res_valid); end
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL kill_redir_nores: got %b want 0", res_valid); end
`ifdef BRU_PERF_EN
    checks++; if (perf_mispreds !== mis_before) begin errors++;
      $display("FAIL kill_redir_perf: got %h want %h", perf_mispreds, mis_before); end
`endif
  endtask

  task automatic test_sel_edges();
    issue(3'd0, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h80, 1'b1);
    step();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin errors++;
      $display("FAIL nop_wrap: got v=%b pc=%h want 1 00000000", redirect_valid, redirect_pc); end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_mispred !== 1'b1) begin errors++;
      $display("FAIL nop_res: got v=%b t=%b m=%b want 1 0 1", res_valid, res_taken, res_mispred); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    issue(3'd7, 32'd3, 32'd3, 32'h400, 32'h8, 1'b0);
    checks++; if (cmp_sel !== 3'd7) begin errors++; $display("FAIL rsv_cmp_sel: got %0d want 7", cmp_sel); end
    step();
    checks++; if (res_valid !== 1'b1 || redirect_valid !== 1'b0 || res_taken !== 1'b0 || res_mispred !== 1'b0) begin errors++;
      $display("FAIL rsv_res: got v=%b rv=%b t=%b m=%b want 1 0 0 0", res_valid, redirect_valid, res_taken, res_mispred); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_kill_idle_eval();
    kill = 1'b1;
    in_sel = 3'd2; in_rs1 = 32'd1; in_rs2 = 32'd2; in_pc = 32'h500; in_imm = 32'h4; in_pred_taken = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; kill = 1'b0;
    checks++; if (in_ready !== 1'b1 || cmp_sel !== 3'd0) begin errors++;
      $display("FAIL kill_idle: got ready=%b sel=%0d want 1 0", in_ready, cmp_sel); end
    step();
    checks++; if (res_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++;
      $display("FAIL kill_idle_out: got res=%b rv=%b want 0 0", res_valid, redirect_valid); end
    issue(3'd2, 32'd1, 32'd2, 32'h500, 32'h4, 1'b0);
    kill = 1'b1;
    step();
    kill = 1'b0;
    checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++;
      $display("FAIL kill_eval: got ready=%b res=%b rv=%b want 1 0 0", in_ready, res_valid, redirect_valid); end
  endtask

  task automatic test_kill_resp();
    logic [31:0] br_before;
    br_before = 32'h0;
`ifdef BRU_PERF_EN
    br_before = perf_branches;
`endif
    issue(3'd4, 32'd9, 32'd2, 32'h600, 32'h10, 1'b1);
    step();
    checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1) begin errors++;
      $display("FAIL bge_res: got v=%b t=%b want 1 1", res_valid, res_taken); end
    kill = 1'b1; res_ready = 1'b1;
    step();
    kill = 1'b0; res_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin errors++;
      $display("FAIL kill_resp: got ready=%b res=%b want 1 0", in_ready, res_valid); end
`ifdef BRU_PERF_EN
    checks++; if (perf_branches !== br_before) begin errors++;
      $display("FAIL kill_resp_perf: got %h want %h", perf_branches, br_before); end
`endif
  endtask

  task automatic test_async_reset();
    issue(3'd6, 32'd1, 32'd2, 32'h700, 32'h40, 1'b1);
    step();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h704) begin errors++;
      $display("FAIL bgeu_redir: got v=%b pc=%h want 1 00000704", redirect_valid, redirect_pc); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0 || in_ready !== 1'b1 || redirect_pc !== 32'h0 || cmp_drs1 !== 32'h0) begin errors++;
      $display("FAIL async_rst: got rv=%b ready=%b pc=%h drs1=%h want 0 1 0 0", redirect_valid, in_ready, redirect_pc, cmp_drs1); end
    step();
    rstn = 1'b1;
    step();
    checks++; if (res_valid !== 1'b0 || redirect_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL async_rst_after: got res=%b rv=%b ready=%b want 0 0 1", res_valid, redirect_valid, in_ready); end
  endtask

`ifdef BRU_PERF_EN
  task automatic test_perf();
    force dut.r_perf_branches = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_branches;
    issue(3'd1, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
    step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++; if (perf_branches !== 32'h0) begin errors++;
      $display("FAIL perf_wrap: got %h want 00000000", perf_branches); end
    issue(3'd2, 32'd5, 32'd6, 32'h100, 32'h20, 1'b0);
    step();
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    checks++; if (perf_mispreds !== 32'd1) begin errors++;
      $display("FAIL perf_mispreds: got %h want 00000001", perf_mispreds); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++; if (perf_branches !== 32'd1) begin errors++;
      $display("FAIL perf_branches: got %h want 00000001", perf_branches); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef BRU_PERF_EN
    test_perf();
`endif
    test_beq_predicted();
    test_blt_redirect();
    test_bltu_stall();
    test_kill_redir();
    test_sel_edges();
    test_kill_idle_eval();
    test_kill_resp();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports (name  dir  width  meaning) SHALL be as listed in REQ-002 to REQ-011.
REQ-002 clk  in  1  sole clock, rising edge; rstn  in  1  asynchronous active-low reset.
REQ-003 in_valid  in  1, in_ready  out  1: branch-issue handshake from decode.
REQ-004 in_sel  in  3  op: 0 nop, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 reserved.
REQ-005 in_rs1, in_rs2  in  32  operands; in_pc  in  32  branch PC; in_imm  in  32  sign-extended offset; in_pred_taken  in  1  fetch prediction.
REQ-006 cmp_sel  out  3, cmp_drs1  out  32, cmp_drs2  out  32: drive the shared branch comparator.
REQ-007 cmp_take  in  1  comparator result, combinational from cmp_* outputs.
REQ-008 kill  in  1  pipeline flush from an older stage.
REQ-009 redirect_valid  out  1, redirect_ready  in  1, redirect_pc  out  32: fetch-redirect handshake.
REQ-010 res_valid  out  1, res_ready  in  1, res_taken  out  1, res_mispred  out  1: resolution to writeback.
REQ-011 With BRU_PERF_EN: perf_branches  out  32, perf_mispreds  out  32.

Function
REQ-012 FSM states SHALL be IDLE, EVAL, REDIR, RESP; in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: in_valid & in_ready & !kill SHALL capture in_sel, in_rs1, in_rs2, in_pc, in_imm and in_pred_taken into registers and go to EVAL.
REQ-014 cmp_sel, cmp_drs1 and cmp_drs2 SHALL come from the captured registers in every state; cmp_sel SHALL be 0 outside EVAL.
REQ-015 EVAL (exactly one cycle): taken = cmp_take when sel is 1..6, 0 when sel is 0 or 7; taken and mispred = (taken != pred_taken) SHALL be registered.
REQ-016 Target SHALL be pc+imm when taken and pc+4 otherwise; addition modulo 2^32, carry discarded.
REQ-017 EVAL SHALL go to REDIR when mispred is 1, else to RESP.
REQ-018 REDIR: redirect_valid=1 and redirect_pc=target, held stable until redirect_ready=1; that cycle SHALL go to RESP.
REQ-019 RESP: res_valid=1 with res_taken and res_mispred stable until res_ready=1; that cycle SHALL go to IDLE.
REQ-020 Latency: accept at edge N -> EVAL in cycle N+1 -> redirect_valid or res_valid first asserted in cycle N+2.
REQ-021 kill=1 in EVAL, REDIR or RESP SHALL force IDLE at the next edge; no redirect or result is issued for that branch.
REQ-022 kill has priority over a same-cycle redirect_ready or res_ready; the handshake SHALL NOT count as completed.
REQ-023 kill=1 in IDLE SHALL block acceptance even when in_valid=1.
REQ-024 redirect_valid and res_valid SHALL never be 1 in the same cycle.

Reset
REQ-025 When rstn=0: state=IDLE; in_ready=1; redirect_valid=0, res_valid=0, res_taken=0, res_mispred=0; redirect_pc=0; cmp_sel=0, cmp_drs1=0, cmp_drs2=0; all captured registers=0; perf counters=0.
REQ-026 Reset during any state SHALL abort the branch immediately, without completing any handshake.

Configuration
REQ-027 Macro BRU_PERF_EN defined: perf_branches SHALL increment on each completed RESP handshake with sel 1..6, and perf_mispreds on each completed REDIR handshake; both wrap 0xFFFFFFFF->0.
REQ-028 Macro BRU_PERF_EN undefined: no perf ports or counters; all other behaviour identical.

Verification
REQ-029 beq, rs1=rs2=5, pred=1, pc=0x100, imm=0x20 -> no redirect; res_valid in cycle N+2 with taken=1, mispred=0.
REQ-030 blt, rs1=0xFFFFFFFF, rs2=1, pred=0, pc=0x200, imm=0x40 -> redirect_pc=0x240; after ready, res taken=1, mispred=1.
REQ-031 bltu with same operands as REQ-030, pred=1 -> redirect_pc=0x204, res taken=0, mispred=1; redirect_ready held 0 for 3 cycles -> redirect_pc stable.
REQ-032 kill asserted in REDIR together with redirect_ready=1 -> IDLE next cycle, no res_valid, perf_mispreds unchanged.
REQ-033 sel=0, pred=1, pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap); sel=7, pred=0 -> res taken=0, mispred=0.
REQ-034 With BRU_PERF_EN, perf_branches preloaded to 0xFFFFFFFF via forced state, one completed beq -> 0.
